seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side monitor for the multiplexed 3-digit seven-segment display bus. It samples the active-low anode and segment lines, waits for each digit to settle, and decodes each segment pattern back to BCD. It reassembles complete units/tens/hundreds frames and publishes them atomically. It sits on the board-pin side of the display driver and is used for self-check and loopback of the BCD counter path.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive synchronized cycles an {an_n, seg_n, dp_n} tuple must hold before it is sampled (≥2).
- TIMEOUT_CYCLES, 65536: cycles without a completed frame before `timeout` asserts.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- an_n  in  3  active-low digit select: 110 = units, 101 = tens, 011 = hundreds, 111 = idle.
- seg_n  in  7  active-low segments, bit0 = a … bit6 = g.
- dp_n  in  1  active-low decimal point.
- digit_u / digit_t / digit_h  out  4 each  published BCD digits; 4'hF = blank, 4'hE = undecodable.
- dp  out  3  published decimal points, active-high, {h,t,u}.
- frame_valid  out  1  one-cycle pulse when new digits are published.
- err  out  1  one-cycle pulse on an illegal anode code or segment pattern.
- timeout  out  1  level; no frame completed within TIMEOUT_CYCLES.
- value  out  10  binary h*100+t*10+u (only with SEG7_SCAN_BIN_EN).

## Operation
- Input stage: 2-flop synchronizer on an_n, seg_n, dp_n. Reset value is all ones (inactive).
- Stability: stab_cnt clears on any change of the synced tuple and saturates at STABLE_CYCLES. The sample strobe fires exactly once per dwell, on the cycle stab_cnt reaches STABLE_CYCLES-1.
- Anode classification at the strobe:
  - 110 → U, 101 → T, 011 → H.
  - 111 → ignored.
  - Any other code → err pulse, no capture.
- Pattern decode:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0011000.
  - 1111111 → 4'hF.
  - Anything else → 4'hE plus an err pulse. The digit is still captured.
- Frame FSM (states WAIT_U, GOT_U, GOT_T):
  - WAIT_U: U → capture u, go to GOT_U. T or H → stay.
  - GOT_U: T → capture t, go to GOT_T. U → recapture u, stay. H → WAIT_U.
  - GOT_T: H → capture h, publish, go to WAIT_U. U → recapture u, go to GOT_U. T → recapture t, stay.
  - Illegal anode code in any state → WAIT_U.
- Publish: digit_*, dp, and value update together in one cycle, with a frame_valid pulse. Outputs hold between publishes.
- timeout: a counter increments every cycle and saturates. It clears on publish. timeout = (count ≥ TIMEOUT_CYCLES). It falls the cycle after frame_valid.
- rst mid-frame drops any partial capture. Published outputs return to their reset values.

## Timing
- Reset values: digit_* = 4'hF, dp = 0, frame_valid = 0, err = 0, timeout = 0, value = 0, FSM = WAIT_U, stab_cnt = 0.
- Latency: the H pattern is stable at the pins from edge k. The strobe occurs at edge k+2+STABLE_CYCLES-1. frame_valid and the new outputs are registered one edge later, at k+2+STABLE_CYCLES.
- err is asserted in the same cycle frame_valid would be for that sample.
- A dwell shorter than STABLE_CYCLES synced cycles is never sampled. Such a glitch is neither an error nor a capture.
- A tuple held indefinitely is sampled once. Rescanning the same digit requires a change, e.g. the idle gap 111.

## Configuration
- SEG7_SCAN_BIN_EN defined:
  - `value` port exists.
  - It is registered at publish as h*100+t*10+u.
  - It is 10'h3FF if any digit is E or F.
- SEG7_SCAN_BIN_EN undefined: the port and arithmetic are removed. All other behaviour is identical.

## Structure
- Package seg7_pkg:
  - Anode codes (AN_U, AN_T, AN_H, AN_IDLE).
  - The ten segment pattern constants plus SEG_BLANK.
  - DIGIT_BLANK = 4'hF and DIGIT_BAD = 4'hE.
  - FSM state enum.
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern → 4-bit digit plus bad flag. It is reused by the testbench scoreboard.

## Test plan
- Scan u=3, t=4, h=5 (seg 0110000/0011001/0010010), STABLE_CYCLES+2 cycles each with 111 gaps → one frame_valid; digits 3/4/5; value 543.
- Drive the H pattern stable from edge k → frame_valid exactly at edge k+2+STABLE_CYCLES. A dwell of STABLE_CYCLES-1 → no capture, no err.
- Units pattern 0101010 → err pulse. Completing the frame → digit_u = 4'hE, value = 10'h3FF.
- Out-of-order scan U, H, T, H → no frame. A subsequent clean U, T, H publishes only the new digits.
- Anode code 100 mid-frame → err and restart in WAIT_U. Apply rst between T and H → outputs 4'hF, no frame_valid.
- No scanning for TIMEOUT_CYCLES → timeout high. The next completed frame → timeout low the cycle after frame_valid.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan monitor.
// Optional binary output is enabled with SEG7_SCAN_BIN_EN.
package seg7_pkg;

  // Active-low anode select codes
  localparam logic [2:0] AN_U    = 3'b110;
  localparam logic [2:0] AN_T    = 3'b101;
  localparam logic [2:0] AN_H    = 3'b011;
  localparam logic [2:0] AN_IDLE = 3'b111;

  // Active-low segment patterns, bit6 = g ... bit0 = a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_BAD   = 4'hE;

  typedef enum logic [1:0] {
    WAIT_U,
    GOT_U,
    GOT_T
  } frame_state_e;

  // Blank or undecodable digits make the binary value meaningless.
  function automatic logic [9:0] digits_to_bin(input logic [3:0] h, input logic [3:0] t,
                                               input logic [3:0] u);
    if (h > 4'd9 || t > 4'd9 || u > 4'd9) begin
      return 10'h3FF;
    end
    return 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(u);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low seven-segment pattern back to a BCD digit.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       bad
);

  always_comb begin
    digit = DIGIT_BAD;
    bad   = 1'b0;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = DIGIT_BLANK;
      default:   bad   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a multiplexed 3-digit seven-segment bus; reassembles u/t/h frames.
// Define SEG7_SCAN_BIN_EN to add the registered binary `value` output.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] an_n,
  input  logic [6:0] seg_n,
  input  logic       dp_n,
  output logic [3:0] digit_u,
  output logic [3:0] digit_t,
  output logic [3:0] digit_h,
  output logic [2:0] dp,
  output logic       frame_valid,
  output logic       err,
  output logic       timeout
`ifdef SEG7_SCAN_BIN_EN
  ,
  output logic [9:0] value
`endif
);

  localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [StabW-1:0] StabSat    = StabW'(STABLE_CYCLES);
  localparam logic [StabW-1:0] StabStrobe = StabW'(STABLE_CYCLES - 1);
  localparam logic [ToW-1:0]   ToSat      = ToW'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------------
  // Input synchronizer and stability filter
  // ---------------------------------------------------------------------------
  logic [10:0] sync1_q, sync2_q, tuple_q;
  logic [StabW-1:0] stab_q, stab_d;
  logic changed, strobe;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      tuple_q <= '1;
      stab_q  <= '0;
    end else begin
      sync1_q <= {an_n, seg_n, dp_n};
      sync2_q <= sync1_q;
      tuple_q <= sync2_q;
      stab_q  <= stab_d;
    end
  end

  // tuple_q is the value under test; stab_q counts how long it has matched sync2_q.
  assign changed = (sync2_q != tuple_q);

  always_comb begin
    stab_d = stab_q;
    if (changed) begin
      stab_d = '0;
    end else if (stab_q != StabSat) begin
      stab_d = stab_q + StabW'(1);
    end
  end

  assign strobe = (stab_q == StabStrobe);

  logic [2:0] samp_an;
  logic [6:0] samp_seg;
  logic       samp_dp;

  assign samp_an  = tuple_q[10:8];
  assign samp_seg = tuple_q[7:1];
  assign samp_dp  = ~tuple_q[0];

  logic [3:0] dec_digit;
  logic       dec_bad;

  seg7_pattern_decode u_decode (
    .seg   (samp_seg),
    .digit (dec_digit),
    .bad   (dec_bad)
  );

  // ---------------------------------------------------------------------------
  // Anode classification and frame FSM
  // ---------------------------------------------------------------------------
  logic hit_u, hit_t, hit_h, hit_bad;

  assign hit_u   = strobe && (samp_an == AN_U);
  assign hit_t   = strobe && (samp_an == AN_T);
  assign hit_h   = strobe && (samp_an == AN_H);
  assign hit_bad = strobe && (samp_an != AN_U) && (samp_an != AN_T) &&
                   (samp_an != AN_H) && (samp_an != AN_IDLE);

  frame_state_e state_q, state_d;
  logic [3:0] cap_u_q, cap_u_d, cap_t_q, cap_t_d;
  logic [1:0] cap_dp_q, cap_dp_d;  // {t, u}
  logic       publish, err_d;

  always_comb begin
    state_d  = state_q;
    cap_u_d  = cap_u_q;
    cap_t_d  = cap_t_q;
    cap_dp_d = cap_dp_q;
    publish  = 1'b0;
    err_d    = hit_bad | ((hit_u | hit_t | hit_h) & dec_bad);

    case (state_q)
      WAIT_U: begin
        if (hit_u) begin
          cap_u_d     = dec_digit;
          cap_dp_d[0] = samp_dp;
          state_d     = GOT_U;
        end
      end
      GOT_U: begin
        if (hit_u) begin
          cap_u_d     = dec_digit;
          cap_dp_d[0] = samp_dp;
        end else if (hit_t) begin
          cap_t_d     = dec_digit;
          cap_dp_d[1] = samp_dp;
          state_d     = GOT_T;
        end else if (hit_h) begin
          state_d = WAIT_U;
        end
      end
      GOT_T: begin
        if (hit_h) begin
          publish = 1'b1;
          state_d = WAIT_U;
        end else if (hit_u) begin
          cap_u_d     = dec_digit;
          cap_dp_d[0] = samp_dp;
          state_d     = GOT_U;
        end else if (hit_t) begin
          cap_t_d     = dec_digit;
          cap_dp_d[1] = samp_dp;
        end
      end
      default: state_d = WAIT_U;
    endcase

    if (hit_bad) begin
      state_d = WAIT_U;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_U;
      cap_u_q  <= DIGIT_BLANK;
      cap_t_q  <= DIGIT_BLANK;
      cap_dp_q <= '0;
    end else begin
      state_q  <= state_d;
      cap_u_q  <= cap_u_d;
      cap_t_q  <= cap_t_d;
      cap_dp_q <= cap_dp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Published outputs
  // ---------------------------------------------------------------------------
  logic [3:0] digit_u_q, digit_t_q, digit_h_q;
  logic [2:0] dp_q;
  logic       frame_valid_q, err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_u_q     <= DIGIT_BLANK;
      digit_t_q     <= DIGIT_BLANK;
      digit_h_q     <= DIGIT_BLANK;
      dp_q          <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      frame_valid_q <= publish;
      err_q         <= err_d;
      if (publish) begin
        digit_u_q <= cap_u_q;
        digit_t_q <= cap_t_q;
        digit_h_q <= dec_digit;
        dp_q      <= {samp_dp, cap_dp_q};
      end
    end
  end

  assign digit_u     = digit_u_q;
  assign digit_t     = digit_t_q;
  assign digit_h     = digit_h_q;
  assign dp          = dp_q;
  assign frame_valid = frame_valid_q;
  assign err         = err_q;

`ifdef SEG7_SCAN_BIN_EN
  logic [9:0] value_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (publish) begin
      value_q <= digits_to_bin(dec_digit, cap_t_q, cap_u_q);
    end
  end

  assign value = value_q;
`endif

  // ---------------------------------------------------------------------------
  // Frame timeout
  // ---------------------------------------------------------------------------
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_q;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (publish) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != ToSat) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  // Registered so the level drops one cycle after the frame_valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= (to_cnt_q >= ToSat);
    end
  end

  assign timeout = timeout_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scoreboard bench for seg7_scan_decoder; frames are queued at stimulus time.
module tb_seg7_scan_decoder;

  localparam int unsigned S  = 4;
  localparam int unsigned TO = 300;

  localparam logic [2:0] A_U    = 3'b110;
  localparam logic [2:0] A_T    = 3'b101;
  localparam logic [2:0] A_H    = 3'b011;
  localparam logic [2:0] A_IDLE = 3'b111;
  localparam logic [6:0] P_BAD  = 7'b0101010;
  localparam logic [6:0] P_OFF  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] digit_u, digit_t, digit_h;
  logic [2:0] dp;
  logic       frame_valid, err, timeout;
`ifdef SEG7_SCAN_BIN_EN
  logic [9:0] value;
`endif

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .digit_u     (digit_u),
    .digit_t     (digit_t),
    .digit_h     (digit_h),
    .dp          (dp),
    .frame_valid (frame_valid),
    .err         (err),
    .timeout     (timeout)
`ifdef SEG7_SCAN_BIN_EN
    ,
    .value       (value)
`endif
  );

  logic [6:0] ref_seg;
  logic [3:0] ref_digit;
  logic       ref_bad;

  seg7_pattern_decode u_ref (
    .seg   (ref_seg),
    .digit (ref_digit),
    .bad   (ref_bad)
  );

  typedef struct packed {
    logic [3:0] u;
    logic [3:0] t;
    logic [3:0] h;
    logic [2:0] dp;
    logic [9:0] val;
  } frame_t;

  frame_t sb[$];
  frame_t mon_exp;
  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  int err_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0011000;
    endcase
  endfunction

  task automatic push(input logic [3:0] u, input logic [3:0] t, input logic [3:0] h,
                      input logic [2:0] dpv, input logic [9:0] val);
    frame_t f;
    f.u = u; f.t = t; f.h = h; f.dp = dpv; f.val = val;
    sb.push_back(f);
  endtask

  task automatic drive(input logic [2:0] an, input logic [6:0] seg, input logic dpn,
                       input int cyc);
    an_n  = an;
    seg_n = seg;
    dp_n  = dpn;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic scan(input logic [2:0] an, input logic [6:0] seg, input logic dpn);
    drive(an, seg, dpn, S + 2);
    drive(A_IDLE, P_OFF, 1'b1, S + 2);
  endtask

  // Output monitor: every frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      frames_seen++;
      check("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("frame_u", 32'(digit_u), 32'(mon_exp.u));
        check("frame_t", 32'(digit_t), 32'(mon_exp.t));
        check("frame_h", 32'(digit_h), 32'(mon_exp.h));
        check("frame_dp", 32'(dp), 32'(mon_exp.dp));
`ifdef SEG7_SCAN_BIN_EN
        check("frame_value", 32'(value), 32'(mon_exp.val));
`endif
      end
    end
    if (!rst && err) err_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, f0, lat, found;
    rst   = 1'b1;
    an_n  = A_IDLE;
    seg_n = P_OFF;
    dp_n  = 1'b1;

    // Standalone pattern decoder table
    for (int d = 0; d < 10; d++) begin
      ref_seg = pat(d);
      #1;
      check("dec_digit", 32'(ref_digit), 32'(d));
      check("dec_bad", 32'(ref_bad), 32'd0);
    end
    ref_seg = P_OFF;
    #1;
    check("dec_blank", 32'(ref_digit), 32'hF);
    check("dec_blank_bad", 32'(ref_bad), 32'd0);
    ref_seg = P_BAD;
    #1;
    check("dec_illegal", 32'(ref_digit), 32'hE);
    check("dec_illegal_bad", 32'(ref_bad), 32'd1);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_u", 32'(digit_u), 32'hF);
    check("rst_t", 32'(digit_t), 32'hF);
    check("rst_h", 32'(digit_h), 32'hF);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
`ifdef SEG7_SCAN_BIN_EN
    check("rst_value", 32'(value), 32'd0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame 5-4-3 with tens decimal point
    push(4'd3, 4'd4, 4'd5, 3'b010, 10'd543);
    scan(A_U, pat(3), 1'b1);
    scan(A_T, pat(4), 1'b0);
    scan(A_H, pat(5), 1'b1);
    check("f1_frames", 32'(frames_seen), 32'd1);
    check("f1_err", 32'(err_seen), 32'd0);
    repeat (5) @(negedge clk);
    check("hold_u", 32'(digit_u), 32'd3);
    check("hold_h", 32'(digit_h), 32'd5);

    // Latency from H pattern at the pins to frame_valid, then hold without rescan
    push(4'd1, 4'd2, 4'd6, 3'b100, 10'd261);
    scan(A_U, pat(1), 1'b1);
    scan(A_T, pat(2), 1'b1);
    an_n  = A_H;
    seg_n = pat(6);
    dp_n  = 1'b0;
    lat   = -1;
    @(posedge clk);
    for (int n = 1; n <= int'(S) + 4; n++) begin
      @(posedge clk);
      #1;
      if (frame_valid && lat < 0) lat = n;
    end
    check("latency", 32'(lat), 32'(S + 2));
    repeat (10) @(negedge clk);
    drive(A_IDLE, P_OFF, 1'b1, S + 2);
    check("held_once", 32'(frames_seen), 32'd2);

    // Undecodable units pattern
    e0 = err_seen;
    push(4'hE, 4'd9, 4'd0, 3'b000, 10'h3FF);
    scan(A_U, P_BAD, 1'b1);
    check("bad_pat_err", 32'(err_seen), 32'(e0 + 1));
    scan(A_T, pat(9), 1'b1);
    scan(A_H, pat(0), 1'b1);
    check("bad_pat_frames", 32'(frames_seen), 32'd3);

    // Dwell one cycle short is ignored entirely
    e0 = err_seen;
    f0 = frames_seen;
    drive(A_U, P_BAD, 1'b1, S - 1);
    drive(A_IDLE, P_OFF, 1'b1, S + 2);
    scan(A_T, pat(7), 1'b1);
    scan(A_H, pat(7), 1'b1);
    check("short_err", 32'(err_seen), 32'(e0));
    check("short_frames", 32'(frames_seen), 32'(f0));

    // Out-of-order U,H,T,H yields nothing; a clean scan then publishes only new digits
    scan(A_U, pat(1), 1'b1);
    scan(A_H, pat(2), 1'b1);
    scan(A_T, pat(3), 1'b1);
    scan(A_H, pat(4), 1'b1);
    check("ooo_frames", 32'(frames_seen), 32'(f0));
    push(4'd6, 4'd7, 4'd8, 3'b000, 10'd876);
    scan(A_U, pat(6), 1'b1);
    scan(A_T, pat(7), 1'b1);
    scan(A_H, pat(8), 1'b1);
    check("clean_frames", 32'(frames_seen), 32'(f0 + 1));

    // Illegal anode mid-frame restarts the FSM
    f0 = frames_seen;
    scan(A_U, pat(2), 1'b1);
    scan(A_T, pat(5), 1'b1);
    e0 = err_seen;
    scan(3'b100, pat(1), 1'b1);
    check("bad_an_err", 32'(err_seen), 32'(e0 + 1));
    scan(A_H, pat(1), 1'b1);
    check("bad_an_frames", 32'(frames_seen), 32'(f0));

    // Reset between T and H drops the partial frame
    scan(A_U, pat(4), 1'b1);
    scan(A_T, pat(4), 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_u", 32'(digit_u), 32'hF);
    check("mid_rst_t", 32'(digit_t), 32'hF);
    check("mid_rst_h", 32'(digit_h), 32'hF);
    check("mid_rst_dp", 32'(dp), 32'd0);
    rst = 1'b0;
    scan(A_H, pat(4), 1'b1);
    check("mid_rst_frames", 32'(frames_seen), 32'(f0));
    check("mid_rst_h_hold", 32'(digit_h), 32'hF);

    // Timeout, then clearing on the next completed frame
    drive(A_IDLE, P_OFF, 1'b1, TO + 10);
    check("timeout_high", 32'(timeout), 32'd1);
    push(4'd0, 4'd0, 4'd9, 3'b000, 10'd900);
    scan(A_U, pat(0), 1'b1);
    scan(A_T, pat(0), 1'b1);
    an_n  = A_H;
    seg_n = pat(9);
    dp_n  = 1'b1;
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (frame_valid) begin
        found = 1;
        break;
      end
    end
    check("to_frame_seen", 32'(found), 32'd1);
    check("to_at_fv", 32'(timeout), 32'd1);
    @(negedge clk);
    check("to_after_fv", 32'(timeout), 32'd0);
    drive(A_IDLE, P_OFF, 1'b1, S + 2);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
